// File: rtl/axis_insert_header_pipe.sv
// axis_insert_header_pipe: streaming AXI-Stream header inserter.
// Realigns payload through a residue register and one output slot.
module axis_insert_header_pipe #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1,
  parameter int PKT_CNT_WD   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    insert_en,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert,
  output logic [PKT_CNT_WD-1:0]   pkt_cnt
);

  localparam int N  = DATA_BYTE_WD;
  localparam int SW = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {
    IDLE, BYPASS, HDR_BODY, FLUSH
  } state_t;

  function automatic logic [BYTE_CNT_WD-1:0] popcnt(
    input logic [N-1:0] k
  );
    popcnt = '0;
    for (int i = 0; i < N; i++)
      popcnt = popcnt + BYTE_CNT_WD'(k[i]);
  endfunction

  function automatic logic [N-1:0] msb_mask(
    input logic [SW-1:0] c
  );
    msb_mask = '0;
    for (int i = 0; i < N; i++)
      msb_mask[N-1-i] = (SW'(i) < c);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_en(
    input logic [N-1:0] k
  );
    byte_en = '0;
    for (int i = 0; i < N; i++)
      byte_en[8*i +: 8] = {8{k[i]}};
  endfunction

  state_t state, state_nxt;

  logic [DATA_WD-1:0]     residue, res_nxt;
  logic [BYTE_CNT_WD-1:0] hcnt, cnt_nxt;
  logic [BYTE_CNT_WD-1:0] k_in, h_ins;
  logic [SW-1:0]          hk_sum;
  logic [DATA_WD-1:0]     din_m, hdr_res;
  logic [2*DATA_WD-1:0]   cat;
  logic                   load, in_fire, hdr_fire;
  logic                   emit, l_nxt;
  logic [DATA_WD-1:0]     d_nxt;
  logic [N-1:0]           k_nxt;

  assign load     = !valid_out || ready_out;
  assign in_fire  = valid_in && ready_in;
  assign hdr_fire = valid_insert && ready_insert;

  assign ready_in = rst_n && load &&
    (state == BYPASS || state == HDR_BODY ||
     (state == IDLE && !insert_en));
  assign ready_insert = rst_n && state == IDLE && insert_en;

  assign k_in   = popcnt(keep_in);
  assign h_ins  = popcnt(keep_insert);
  assign hk_sum = SW'(hcnt) + SW'(k_in);
  assign din_m  = data_in & byte_en(keep_in);

  // Header bytes arrive LSB-aligned; residue keeps them MSB-aligned.
  assign hdr_res = (data_insert & byte_en(keep_insert))
                   << (8 * (N - int'(h_ins)));

  // Upper half is the next output beat, lower half the new residue.
  assign cat = {residue, {DATA_WD{1'b0}}} |
               ({{DATA_WD{1'b0}}, din_m}
                << (8 * (N - int'(hcnt))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (insert_en) begin
          if (hdr_fire) state_nxt = HDR_BODY;
        end else if (in_fire && !last_in) begin
          state_nxt = BYPASS;
        end
      end
      BYPASS: begin
        if (in_fire && last_in) state_nxt = IDLE;
      end
      HDR_BODY: begin
        if (in_fire && last_in)
          state_nxt = (hk_sum > SW'(N)) ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (load) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    emit    = 1'b0;
    d_nxt   = '0;
    k_nxt   = '0;
    l_nxt   = 1'b0;
    res_nxt = residue;
    cnt_nxt = hcnt;
    unique case (state)
      IDLE: begin
        if (insert_en) begin
          if (hdr_fire) begin
            res_nxt = hdr_res;
            cnt_nxt = h_ins;
          end
        end else begin
          emit  = in_fire;
          d_nxt = din_m;
          k_nxt = keep_in;
          l_nxt = last_in;
        end
      end
      BYPASS: begin
        emit  = in_fire;
        d_nxt = din_m;
        k_nxt = keep_in;
        l_nxt = last_in;
      end
      HDR_BODY: begin
        if (in_fire) begin
          emit  = 1'b1;
          d_nxt = cat[2*DATA_WD-1:DATA_WD];
          unique case (1'b1)
            last_in && hk_sum <= SW'(N): begin
              k_nxt = msb_mask(hk_sum);
              l_nxt = 1'b1;
            end
            last_in && hk_sum > SW'(N): begin
              k_nxt   = '1;
              res_nxt = cat[DATA_WD-1:0];
              cnt_nxt = BYTE_CNT_WD'(hk_sum - SW'(N));
            end
            default: begin
              k_nxt   = '1;
              res_nxt = cat[DATA_WD-1:0];
            end
          endcase
        end
      end
      FLUSH: begin
        if (load) begin
          emit  = 1'b1;
          d_nxt = residue;
          k_nxt = msb_mask(SW'(hcnt));
          l_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
      residue   <= '0;
      hcnt      <= '0;
      pkt_cnt   <= '0;
    end else begin
      if (load) begin
        valid_out <= emit;
        data_out  <= d_nxt;
        keep_out  <= k_nxt;
        last_out  <= l_nxt;
      end
      residue <= res_nxt;
      hcnt    <= cnt_nxt;
      if (valid_out && ready_out && last_out)
        pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_insert_header_pipe.sv
// tb_axis_insert_header_pipe: table vectors, random packets vs a
// byte-queue reference model, reset and counter-wrap sequences.
module tb_axis_insert_header_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        insert_en, valid_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  axis_insert_header_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .last_in      (last_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .keep_out     (keep_out),
    .last_out     (last_out),
    .ready_out    (ready_out),
    .insert_en    (insert_en),
    .valid_insert (valid_insert),
    .data_insert  (data_insert),
    .keep_insert  (keep_insert),
    .ready_insert (ready_insert),
    .pkt_cnt      (pkt_cnt)
  );

  typedef struct {
    bit           ins;
    logic [31:0]  hd;
    logic [3:0]   hk;
    int           nb;
    logic [127:0] pd;
    logic [3:0]   lk;
    int           ne;
    logic [127:0] ed;
    logic [15:0]  ek;
    logic [3:0]   el;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  vec_t        vt[5];
  logic [31:0] pdat[0:7];
  logic [3:0]  lkeep;
  int          nbeats;
  int          total = 0;
  int          passed = 0;
  int          exp_pkts = 0;
  bit          mon_off = 1'b0;
  bit          stall_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    total++;
    $display("FAIL %s: timeout, got no response expected handshake", nm);
  endtask

  function automatic vec_t mk(
    input bit ins, input logic [31:0] hd, input logic [3:0] hk,
    input int nb, input logic [127:0] pd, input logic [3:0] lk,
    input int ne, input logic [127:0] ed, input logic [15:0] ek,
    input logic [3:0] el);
    vec_t v;
    v.ins = ins; v.hd = hd; v.hk = hk; v.nb = nb; v.pd = pd;
    v.lk = lk; v.ne = ne; v.ed = ed; v.ek = ek; v.el = el;
    return v;
  endfunction

  // Reference: flatten header and payload into bytes, rechunk by 4.
  task automatic model_pkt(input bit ins, input logic [31:0] hd,
                           input logic [3:0] hk);
    logic [7:0] bq[$];
    beat_t b;
    int h, kc;
    if (ins) begin
      h = $countones(hk);
      for (int i = h - 1; i >= 0; i--) bq.push_back(hd[8*i +: 8]);
    end
    for (int j = 0; j < nbeats; j++) begin
      kc = (j == nbeats - 1) ? $countones(lkeep) : 4;
      for (int i = 0; i < kc; i++) bq.push_back(pdat[j][31-8*i -: 8]);
    end
    while (bq.size() > 0) begin
      b.d = '0;
      b.k = '0;
      for (int i = 0; i < 4 && bq.size() > 0; i++) begin
        b.d[31-8*i -: 8] = bq.pop_front();
        b.k[3-i] = 1'b1;
      end
      b.l = (bq.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_rdy(input bit hdr, input string nm);
    int t = 0;
    bit ok = 1'b0;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = hdr ? ready_insert : ready_in;
      t++;
    end
    if (!ok) tmo(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input bit ins, input logic [31:0] hd,
                          input logic [3:0] hk);
    insert_en = ins;
    if (ins) begin
      valid_insert = 1'b1;
      data_insert  = hd;
      keep_insert  = hk;
      wait_rdy(1'b1, "hdr_hs");
      valid_insert = 1'b0;
    end
    for (int j = 0; j < nbeats; j++) begin
      valid_in = 1'b1;
      data_in  = pdat[j];
      last_in  = (j == nbeats - 1);
      keep_in  = last_in ? lkeep : 4'hF;
      wait_rdy(1'b0, "pay_hs");
      valid_in = 1'b0;
      last_in  = 1'b0;
      if (!ins) chk("byp_ready_insert", ready_insert, 0);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      tmo("drain");
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int v);
    beat_t b;
    nbeats = vt[v].nb;
    for (int j = 0; j < 4; j++) pdat[j] = vt[v].pd[127-32*j -: 32];
    lkeep = vt[v].lk;
    for (int i = 0; i < vt[v].ne; i++) begin
      b.d = vt[v].ed[127-32*i -: 32];
      b.k = vt[v].ek[15-4*i -: 4];
      b.l = vt[v].el[3-i];
      exp_q.push_back(b);
    end
    exp_pkts++;
    send_pkt(vt[v].ins, vt[v].hd, vt[v].hk);
    drain();
    chk("pkt_cnt_vec", pkt_cnt, exp_pkts);
  endtask

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard, hold-while-stalled, ready_in backpressure.
  initial begin
    beat_t e;
    bit hold = 1'b0;
    logic [31:0] hd_q;
    logic [3:0]  hk_q;
    logic        hl_q;
    forever begin
      @(negedge clk);
      if (rst_n && !mon_off) begin
        if (hold) begin
          chk("hold_valid", valid_out, 1);
          chk("hold_data", data_out, hd_q);
          chk("hold_keep", keep_out, hk_q);
          chk("hold_last", last_out, hl_q);
        end
        if (valid_out && !ready_out) chk("stall_ready_in", ready_in, 0);
        hold = valid_out && !ready_out;
        hd_q = data_out;
        hk_q = keep_out;
        hl_q = last_out;
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL extra_beat: got %0h/%0h expected none",
                     data_out, keep_out);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", data_out, e.d);
            chk("beat_keep", keep_out, e.k);
            chk("beat_last", last_out, e.l);
          end
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    int acc, it;
    bit a;
    bit ins;
    int h, kc;
    logic [31:0] hd;
    logic [3:0] hk;

    vt[0] = mk(1, 32'h0000AABB, 4'b0011, 2,
      {32'h11223344, 32'h55667788, 64'h0}, 4'hF, 3,
      {32'hAABB1122, 32'h33445566, 32'h77880000, 32'h0},
      {4'hF, 4'hF, 4'hC, 4'h0}, 4'b0010);
    vt[1] = mk(1, 32'h000000CC, 4'b0001, 1,
      {32'h11223300, 96'h0}, 4'hE, 1,
      {32'hCC112233, 96'h0}, {4'hF, 12'h0}, 4'b1000);
    vt[2] = mk(0, 32'h0, 4'h0, 3,
      {32'h01020304, 32'h05060708, 32'h09000000, 32'h0}, 4'h8, 3,
      {32'h01020304, 32'h05060708, 32'h09000000, 32'h0},
      {4'hF, 4'hF, 4'h8, 4'h0}, 4'b0010);
    vt[3] = mk(1, 32'hDEADBEEF, 4'hF, 2,
      {32'h11223344, 32'h55667788, 64'h0}, 4'hF, 3,
      {32'hDEADBEEF, 32'h11223344, 32'h55667788, 32'h0},
      {4'hF, 4'hF, 4'hF, 4'h0}, 4'b0010);
    vt[4] = mk(1, 32'h00112233, 4'b0111, 1,
      {32'hAABBCC00, 96'h0}, 4'hE, 2,
      {32'h112233AA, 32'hBBCC0000, 64'h0},
      {4'hF, 4'hC, 8'h0}, 4'b0100);

    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    insert_en = 1'b0; valid_insert = 1'b0;
    data_insert = '0; keep_insert = '0;
    #12;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_last_out", last_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_keep_out", keep_out, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_ready_in", ready_in, 0);
    chk("rst_ready_insert", ready_insert, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) run_vec(v);

    stall_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      ins = 1'($urandom_range(0, 1));
      h = $urandom_range(1, 4);
      hk = 4'hF >> (4 - h);
      hd = $urandom;
      nbeats = $urandom_range(1, 4);
      for (int j = 0; j < nbeats; j++) pdat[j] = $urandom;
      kc = $urandom_range(1, 4);
      lkeep = 4'hF << (4 - kc);
      model_pkt(ins, hd, hk);
      exp_pkts++;
      send_pkt(ins, hd, hk);
    end
    drain();
    stall_en = 1'b0;
    @(posedge clk);
    #1;
    chk("pkt_cnt_rand", pkt_cnt, exp_pkts);

    mon_off = 1'b1;
    insert_en = 1'b1;
    valid_insert = 1'b1;
    data_insert = 32'h0000AABB;
    keep_insert = 4'b0011;
    wait_rdy(1'b1, "rst_hdr_hs");
    valid_insert = 1'b0;
    valid_in = 1'b1;
    data_in = 32'h11223344;
    keep_in = 4'hF;
    last_in = 1'b0;
    wait_rdy(1'b0, "rst_pay_hs");
    valid_in = 1'b0;
    chk("pre_rst_valid", valid_out, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_out", valid_out, 0);
    chk("mid_rst_last_out", last_out, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_keep_out", keep_out, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    chk("mid_rst_ready_in", ready_in, 0);
    chk("mid_rst_ready_insert", ready_insert, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_pkts = 0;
    mon_off = 1'b0;
    @(posedge clk);
    #1;
    run_vec(1);

    mon_off = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    insert_en = 1'b0;
    valid_in = 1'b1;
    last_in = 1'b1;
    keep_in = 4'hF;
    data_in = 32'h0;
    acc = 0;
    it = 0;
    while (acc < 65535 && it < 70000) begin
      @(negedge clk);
      a = ready_in;
      @(posedge clk);
      #1;
      if (a) acc++;
      it++;
    end
    valid_in = 1'b0;
    if (acc < 65535) tmo("wrap_fill");
    repeat (3) @(posedge clk);
    #1;
    chk("pkt_cnt_max", pkt_cnt, 16'hFFFF);
    valid_in = 1'b1;
    wait_rdy(1'b0, "wrap_last_hs");
    valid_in = 1'b0;
    last_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pkt_cnt_wrap", pkt_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_insert_header_pipe.md
Name: axis_insert_header_pipe

Overview:
- Streaming, full-throughput successor to the packet-buffered header inserter in the axi_stream library.
- Prepends a 1..DATA_BYTE_WD-byte header to each AXI-Stream packet and realigns the payload on the fly. Uses a residue register and a single output stage, with no whole-packet buffer, so packet length is unbounded.
- Per-packet bypass mode and a packet counter.
- Sits between the payload source and the framing/egress stage.

Parameters:
- DATA_WD, 32, stream data width in bits; multiple of 8, 16..512.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (N below).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD)+1, width of byte counts, holds 0..N.
- PKT_CNT_WD, 16, width of pkt_cnt.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  payload beat valid
- data_in  in  DATA_WD  payload; byte 0 = data_in[DATA_WD-1 -: 8] (MSB-first)
- keep_in  in  DATA_BYTE_WD  byte enables; all ones except on the last beat, where they are MSB-aligned contiguous and nonzero
- last_in  in  1  last payload beat
- ready_in  out  1  payload accepted when valid_in&&ready_in
- valid_out  out  1  output beat valid
- data_out  out  DATA_WD  output data, MSB-first
- keep_out  out  DATA_BYTE_WD  output byte enables, MSB-aligned contiguous
- last_out  out  1  last output beat
- ready_out  in  1  downstream ready
- insert_en  in  1  sampled at packet start: 1 = insert header, 0 = bypass
- valid_insert  in  1  header valid
- data_insert  in  DATA_WD  header; valid bytes LSB-aligned
- keep_insert  in  DATA_BYTE_WD  header enables; LSB-aligned contiguous, nonzero
- ready_insert  out  1  header accepted when valid_insert&&ready_insert
- pkt_cnt  out  PKT_CNT_WD  count of completed output packets; wraps

Behaviour:
- Reset: state=IDLE. valid_out, last_out, data_out, keep_out, pkt_cnt and residue are all 0. ready_in=0, ready_insert=0.
- Output stage: a single register slot.
  - The slot can load when it is empty or when ready_out=1 (load = !valid_out || ready_out).
  - valid_out, data_out, keep_out and last_out are held stable while valid_out && !ready_out.
- IDLE:
  - If insert_en=1: ready_insert=1 and ready_in=0. On header handshake, H=popcount(keep_insert) and residue = the H valid header bytes; go to HDR_BODY.
  - If insert_en=0: go to BYPASS with no cycle consumed. ready_in=load, ready_insert=0.
- BYPASS:
  - Each accepted beat is copied unchanged to the output slot; latency 1 cycle.
  - Accepted last_in returns the FSM to IDLE.
- HDR_BODY: ready_in=load, ready_insert=0. On each accepted beat with K=popcount(keep_in):
  - Non-last beat: out = residue(H bytes) ++ data_in bytes 0..N-H-1; keep all ones. New residue = data_in bytes N-H..N-1.
  - Last beat with H+K<=N: out = residue ++ first K bytes; keep = H+K ones MSB-aligned; last_out=1. Return to IDLE.
  - Last beat with H+K>N: emit a full beat with last_out=0, store the leftover H+K-N bytes, go to FLUSH.
- FLUSH:
  - ready_in=0, ready_insert=0.
  - When load: out = leftover bytes, keep = H+K-N ones, last_out=1. Return to IDLE.
- H=N is legal: the header becomes a full beat and the payload is delayed by one beat.
- Latency: header-inserted output appears 1 cycle after the first payload beat handshake. Throughput is one beat/cycle, plus one extra cycle per packet only when FLUSH is entered.
- The header is never emitted alone; a packet requires at least 1 payload beat.
- pkt_cnt increments when valid_out&&ready_out&&last_out; it wraps 2^PKT_CNT_WD-1 -> 0.
- insert_en is ignored outside IDLE. valid_insert is ignored outside IDLE (no handshake).
- Unused data_out bytes (keep_out=0) are driven 0.
- Reset asserted mid-packet: all state is cleared immediately, the partial packet is discarded, and no last_out is generated.
- Illegal keep patterns (non-contiguous, zero) produce undefined output but must not lock the FSM.

Test Plan (N=4):
- Header keep_insert=0011, data_insert=0x0000AABB, payload 0x11223344 then 0x55667788 (last, keep 1111) -> out 0xAABB1122/1111, 0x33445566/1111, then FLUSH 0x77880000/1100 last. pkt_cnt=1.
- Header keep=0001 (0xCC), single payload 0x11223300 keep 1110 last -> one beat 0xCC112233/1111 last_out=1, no FLUSH.
- insert_en=0, three-beat packet with last keep 1000 -> identical beats out 1 cycle later; ready_insert stays 0.
- Header keep=1111, 2-beat payload -> 3 output beats: header beat then the payload unchanged; last keep matches keep_in.
- ready_out toggled 1,0,0,1 randomly mid-packet -> output held stable while stalled, no beat lost or duplicated, ready_in=0 while stalled.
- rst_n pulsed low during HDR_BODY -> all outputs 0 next edge. A following packet is correct and pkt_cnt restarts at 0.
- Back-to-back 2^16 packets -> pkt_cnt wraps to 0.
